// File: rtl/axil_wr_arbiter.sv
// AXI-Lite write-path arbiter: round-robin master grant, slave address decode,
// one-hot mux selects held until the B handshake, and a local DECERR responder.
module axil_wr_arbiter #(
  parameter int NUMBER_MASTER  = 2,
  parameter int NUMBER_SLAVE   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter logic [NUMBER_SLAVE*AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET =
    {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000},
  parameter logic [NUMBER_SLAVE*AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE =
    {32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF}
) (
  input  logic                                    aclk,
  input  logic                                    areset,
  input  logic [NUMBER_MASTER*AXI_ADDR_WIDTH-1:0] m_axil_awaddr,
  input  logic [NUMBER_MASTER-1:0]                m_axil_awvalid,
  input  logic [NUMBER_MASTER-1:0]                m_axil_bready,
  input  logic                                    aw_done,
  input  logic                                    w_done,
  input  logic                                    b_done,
  output logic [NUMBER_MASTER-1:0]                grant_m,
  output logic [NUMBER_SLAVE-1:0]                 grant_s,
  output logic                                    err_awready,
  output logic                                    err_wready,
  output logic                                    err_bvalid,
  output logic [NUMBER_MASTER-1:0]                addr_illegal
);

  localparam int MW = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1;

  typedef enum logic [2:0] {IDLE, ACTIVE, RESP, ERR_AW, ERR_W, ERR_B} state_t;

  state_t                        state, state_nxt;
  logic [MW-1:0]                 rr_ptr, rr_next, winner, arb_idx;
  logic                          arb_found;
  logic [2*NUMBER_MASTER-1:0]    req_rot;
  logic [NUMBER_MASTER-1:0]      arb_onehot;
  logic [AXI_ADDR_WIDTH-1:0]     arb_addr;
  logic [NUMBER_SLAVE-1:0]       dec_sel;
  logic                          dec_hit;
  logic                          aw_seen, w_seen;
  logic                          bready_win;

  // Window test is done one bit wider so base+range never wraps.
  function automatic logic in_window(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                     input logic [AXI_ADDR_WIDTH-1:0] base,
                                     input logic [AXI_ADDR_WIDTH-1:0] span);
    logic [AXI_ADDR_WIDTH:0] top;
    top = {1'b0, base} + {1'b0, span};
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} <= top);
  endfunction

  // Rotate requests so bit 0 is the master at rr_ptr; first set bit wins.
  always_comb begin
    req_rot   = {m_axil_awvalid, m_axil_awvalid} >> rr_ptr;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < NUMBER_MASTER; k++) begin
      if (!arb_found && req_rot[k]) begin
        arb_found = 1'b1;
        arb_idx   = (int'(rr_ptr) + k >= NUMBER_MASTER) ?
                    MW'(int'(rr_ptr) + k - NUMBER_MASTER) : MW'(int'(rr_ptr) + k);
      end
    end
    arb_onehot = NUMBER_MASTER'(1) << arb_idx;
  end

  always_comb begin
    arb_addr = '0;
    for (int i = 0; i < NUMBER_MASTER; i++) begin
      if (arb_idx == MW'(i)) arb_addr = m_axil_awaddr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    end
  end

  // Lowest-index window wins when windows overlap.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int i = 0; i < NUMBER_SLAVE; i++) begin
      if (!dec_hit && in_window(arb_addr,
                                AXI_ADDR_OFFSET[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH],
                                AXI_ADDR_RANGE[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH])) begin
        dec_hit    = 1'b1;
        dec_sel[i] = 1'b1;
      end
    end
  end

  assign bready_win = |(m_axil_bready & grant_m);
  assign rr_next    = (winner == MW'(NUMBER_MASTER - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    err_awready  = 1'b0;
    err_wready   = 1'b0;
    err_bvalid   = 1'b0;
    addr_illegal = '0;
    case (state)
      IDLE:   if (arb_found) state_nxt = dec_hit ? ACTIVE : ERR_AW;
      ACTIVE: if ((aw_seen | aw_done) && (w_seen | w_done)) state_nxt = RESP;
      RESP:   if (b_done) state_nxt = IDLE;
      ERR_AW: begin
        err_awready  = 1'b1;
        addr_illegal = grant_m;
        state_nxt    = ERR_W;
      end
      ERR_W: begin
        err_wready = 1'b1;
        if (w_done) state_nxt = ERR_B;
      end
      ERR_B: begin
        err_bvalid = 1'b1;
        if (bready_win) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      grant_m <= '0;
      grant_s <= '0;
      winner  <= '0;
      rr_ptr  <= '0;
      aw_seen <= 1'b0;
      w_seen  <= 1'b0;
    end else begin
      if (state == IDLE && arb_found) begin
        grant_m <= arb_onehot;
        grant_s <= dec_hit ? dec_sel : '0;
        winner  <= arb_idx;
        aw_seen <= 1'b0;
        w_seen  <= 1'b0;
      end
      if (state == ACTIVE) begin
        aw_seen <= aw_seen | aw_done;
        w_seen  <= w_seen | w_done;
      end
      if ((state == RESP || state == ERR_B) && state_nxt == IDLE) begin
        grant_m <= '0;
        grant_s <= '0;
        rr_ptr  <= rr_next;
      end
    end
  end

endmodule

// File: tb/tb_axil_wr_arbiter.sv
// Bench for axil_wr_arbiter: stimulus queues expected grants, a negedge monitor
// compares each new grant against the queue head.
module tb_axil_wr_arbiter;
  localparam int NM = 2;
  localparam int NS = 4;
  localparam int AW = 32;

  logic              aclk = 1'b0;
  logic              areset;
  logic [NM*AW-1:0]  m_axil_awaddr;
  logic [NM-1:0]     m_axil_awvalid;
  logic [NM-1:0]     m_axil_bready;
  logic              aw_done, w_done, b_done;
  logic [NM-1:0]     grant_m;
  logic [NS-1:0]     grant_s;
  logic              err_awready, err_wready, err_bvalid;
  logic [NM-1:0]     addr_illegal;

  axil_wr_arbiter #(
    .NUMBER_MASTER(NM), .NUMBER_SLAVE(NS), .AXI_ADDR_WIDTH(AW)
  ) dut (
    .aclk(aclk), .areset(areset),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid),
    .m_axil_bready(m_axil_bready),
    .aw_done(aw_done), .w_done(w_done), .b_done(b_done),
    .grant_m(grant_m), .grant_s(grant_s),
    .err_awready(err_awready), .err_wready(err_wready), .err_bvalid(err_bvalid),
    .addr_illegal(addr_illegal)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [NM-1:0] m;
    logic [NS-1:0] s;
    logic [NM-1:0] ill;
    logic          awr;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [NM-1:0] prev_gm = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_grant(input logic [NM-1:0] m, input logic [NS-1:0] s, input logic ill);
    exp_t e;
    e.m   = m;
    e.s   = s;
    e.ill = ill ? m : '0;
    e.awr = ill;
    exp_q.push_back(e);
  endtask

  task automatic set_addr(input int m, input logic [AW-1:0] a);
    m_axil_awaddr[m*AW +: AW] = a;
  endtask

  // Monitor: every fresh grant is one response to compare.
  always @(negedge aclk) begin
    exp_t e;
    if (grant_m != '0 && prev_gm == '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", 32'(grant_m), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("grant_m", 32'(grant_m), 32'(e.m));
        chk("grant_s", 32'(grant_s), 32'(e.s));
        chk("addr_illegal", 32'(addr_illegal), 32'(e.ill));
        chk("err_awready", 32'(err_awready), 32'(e.awr));
      end
    end
    prev_gm = grant_m;
  end

  // Starts on the negedge after a legal grant; b_done rides with the last
  // AW/W handshake and must be ignored because the FSM is not yet in RESP.
  task automatic complete(input int order, input logic [NM-1:0] em, input logic [NS-1:0] es);
    case (order)
      0: begin
        aw_done = 1'b1; @(negedge aclk);
        aw_done = 1'b0; w_done = 1'b1; b_done = 1'b1; @(negedge aclk);
        w_done = 1'b0; b_done = 1'b0;
      end
      1: begin
        w_done = 1'b1; @(negedge aclk);
        w_done = 1'b0; aw_done = 1'b1; b_done = 1'b1; @(negedge aclk);
        aw_done = 1'b0; b_done = 1'b0;
      end
      default: begin
        aw_done = 1'b1; w_done = 1'b1; b_done = 1'b1; @(negedge aclk);
        aw_done = 1'b0; w_done = 1'b0; b_done = 1'b0;
      end
    endcase
    @(negedge aclk);
    chk("resp_hold_m", 32'(grant_m), 32'(em));
    chk("resp_hold_s", 32'(grant_s), 32'(es));
    b_done = 1'b1; @(negedge aclk);
    b_done = 1'b0;
    chk("idle_grant_m", 32'(grant_m), 32'h0);
    chk("idle_grant_s", 32'(grant_s), 32'h0);
  endtask

  // Starts on the negedge where ERR_AW is visible.
  task automatic err_complete(input int m);
    logic [NM-1:0] mine;
    mine = NM'(1) << m;
    @(negedge aclk);
    chk("err_w_wready", 32'(err_wready), 32'h1);
    chk("err_w_awready", 32'(err_awready), 32'h0);
    chk("err_w_illegal", 32'(addr_illegal), 32'h0);
    chk("err_w_grant", 32'({grant_m, grant_s}), 32'({mine, 4'b0000}));
    @(negedge aclk);
    chk("err_w_wait", 32'(err_wready), 32'h1);
    w_done = 1'b1; @(negedge aclk);
    w_done = 1'b0;
    chk("err_b_bvalid", 32'({err_wready, err_bvalid}), 32'b01);
    m_axil_bready = ~mine; @(negedge aclk);
    chk("err_b_wrong_bready", 32'(err_bvalid), 32'h1);
    m_axil_bready = mine; @(negedge aclk);
    m_axil_bready = '0;
    chk("err_done", 32'({grant_m, err_bvalid}), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge aclk); areset = 1'b1;
    @(negedge aclk); areset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    m_axil_awaddr = '0; m_axil_awvalid = '0; m_axil_bready = '0;
    aw_done = 1'b0; w_done = 1'b0; b_done = 1'b0;
    repeat (2) @(negedge aclk);
    chk("reset_outputs", 32'({grant_m, grant_s, err_awready, err_wready, err_bvalid, addr_illegal}), 32'h0);
    areset = 1'b0;
    @(negedge aclk);
    chk("idle_no_req", 32'({grant_m, grant_s, err_awready, err_wready, err_bvalid, addr_illegal}), 32'h0);

    // Single legal write from M0 to slave 0.
    expect_grant(2'b01, 4'b0001, 1'b0);
    set_addr(0, 32'h1000_0010); m_axil_awvalid = 2'b01;
    @(negedge aclk); m_axil_awvalid = '0;
    complete(0, 2'b01, 4'b0001);

    // Both masters held requesting: M0, M1, M0 from a fresh pointer.
    do_reset();
    set_addr(0, 32'h2000_0000); set_addr(1, 32'h3000_0004);
    expect_grant(2'b01, 4'b0010, 1'b0);
    expect_grant(2'b10, 4'b0100, 1'b0);
    expect_grant(2'b01, 4'b0010, 1'b0);
    m_axil_awvalid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      if (k == 2) m_axil_awvalid = '0;
      complete(0, (k == 1) ? 2'b10 : 2'b01, (k == 1) ? 4'b0100 : 4'b0010);
    end

    // Unmapped address from M1.
    expect_grant(2'b10, 4'b0000, 1'b1);
    set_addr(1, 32'h5000_0000); m_axil_awvalid = 2'b10;
    @(negedge aclk); m_axil_awvalid = '0;
    err_complete(1);

    // Handshake ordering: W before AW, then both together.
    set_addr(0, 32'h3000_0000);
    expect_grant(2'b01, 4'b0100, 1'b0);
    m_axil_awvalid = 2'b01;
    @(negedge aclk); m_axil_awvalid = '0;
    complete(1, 2'b01, 4'b0100);
    expect_grant(2'b01, 4'b0100, 1'b0);
    m_axil_awvalid = 2'b01;
    @(negedge aclk); m_axil_awvalid = '0;
    complete(2, 2'b01, 4'b0100);

    // Window edges.
    set_addr(0, 32'h1000_FFFF);
    expect_grant(2'b01, 4'b0001, 1'b0);
    m_axil_awvalid = 2'b01;
    @(negedge aclk); m_axil_awvalid = '0;
    complete(0, 2'b01, 4'b0001);
    set_addr(0, 32'h1001_0000);
    expect_grant(2'b01, 4'b0000, 1'b1);
    m_axil_awvalid = 2'b01;
    @(negedge aclk); m_axil_awvalid = '0;
    err_complete(0);
    set_addr(0, 32'h4000_FFFF);
    expect_grant(2'b01, 4'b1000, 1'b0);
    m_axil_awvalid = 2'b01;
    @(negedge aclk); m_axil_awvalid = '0;
    complete(2, 2'b01, 4'b1000);

    // Reset while waiting for B, then pointer restarts at M0.
    set_addr(1, 32'h2000_0100);
    expect_grant(2'b10, 4'b0010, 1'b0);
    m_axil_awvalid = 2'b10;
    @(negedge aclk); m_axil_awvalid = '0;
    aw_done = 1'b1; w_done = 1'b1;
    @(negedge aclk); aw_done = 1'b0; w_done = 1'b0;
    chk("pre_reset_resp", 32'({grant_m, grant_s}), 32'({2'b10, 4'b0010}));
    #2 areset = 1'b1;
    #1 chk("async_reset_outputs",
           32'({grant_m, grant_s, err_awready, err_wready, err_bvalid, addr_illegal}), 32'h0);
    @(negedge aclk); areset = 1'b0;
    set_addr(0, 32'h4000_0000);
    expect_grant(2'b01, 4'b1000, 1'b0);
    m_axil_awvalid = 2'b11;
    @(negedge aclk); m_axil_awvalid = '0;
    complete(0, 2'b01, 4'b1000);

    repeat (3) @(negedge aclk);
    chk("pending_expectations", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
